pixel_readout_ctrl: RTL and testbench

- Clocked controller on the far end of the 4-pixel array's shared tri-state DATA bus.
- Sequences one frame: ERASE, EXPOSE, CONVERT (drives the ADC ramp-count code onto DATA), then READ0..READ3.
- During READ it samples each pixel's latched code off DATA and streams it out over a valid/ready interface to the downstream frame logic.

---
 rtl/pixel_readout_pkg.sv | 50 +++++
 rtl/pixel_conv_counter.sv | 57 +++++
 rtl/pixel_readout_ctrl.sv | 134 +++++++++++++
 tb/tb_pixel_readout_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_readout_pkg.sv
// Shared types, constants and code-conversion helpers for the pixel readout controller.
//   state_t          : controller state encoding
//   NPIX / IDX_W     : pixel count and pixel-index width (independent of DW)
//   bin2gray/gray2bin: width-generic conversions; operands are masked to the
//                      requested width inside a fixed CODE_MAX_W container
package pixel_readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_TURN,
        ST_RD_SETTLE,
        ST_RD_OUT,
        ST_DONE
    } state_t;

    localparam int NPIX       = 4;
    localparam int IDX_W      = 2;
    localparam int CODE_MAX_W = 32;

    // Low w bits set; a shift of the full container width yields all ones.
    function automatic logic [CODE_MAX_W-1:0] width_mask(input int w);
        logic [CODE_MAX_W-1:0] ones;
        ones = '1;
        return ~(ones << w);
    endfunction

    function automatic logic [CODE_MAX_W-1:0] bin2gray(input logic [CODE_MAX_W-1:0] b,
                                                       input int w);
        logic [CODE_MAX_W-1:0] m;
        m = b & width_mask(w);
        return m ^ (m >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [CODE_MAX_W-1:0] gray2bin(input logic [CODE_MAX_W-1:0] g,
                                                       input int w);
        logic [CODE_MAX_W-1:0] m;
        logic [CODE_MAX_W-1:0] b;
        m = g & width_mask(w);
        b = m;
        for (int i = CODE_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ m[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pixel_conv_counter.sv
// CONVERT ramp counter and DATA bus driver.
// Optional build macro: DATA_GRAY_EN (drive Gray-coded count instead of binary).
// Ports:
//   clk   in     system clock
//   reset in     asynchronous active-low reset
//   run   in     high while the controller is in CONVERT; also the bus drive enable
//   data  inout  shared pixel bus; driven with the registered code only while run=1
//   tc    out    count has reached its last value (2**DW-1)
module pixel_conv_counter
    import pixel_readout_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    inout  wire  [DW-1:0] data,
    output logic          tc
);

    localparam logic [DW-1:0] CNT_LAST = '1;

    logic [DW-1:0] count_reg;
    logic [DW-1:0] count_next;
    logic [DW-1:0] code_reg;
    logic [DW-1:0] code_next;

    // The count is cleared whenever run is low, so every CONVERT starts at 0.
    // It saturates at the last value instead of wrapping.
    always_comb begin
        count_next = '0;
        if (run) begin
            count_next = (count_reg == CNT_LAST) ? count_reg : count_reg + 1'b1;
        end
`ifdef DATA_GRAY_EN
        code_next = DW'(bin2gray(CODE_MAX_W'(count_next), DW));
`else
        code_next = count_next;
`endif
    end

    // The bus code is registered alongside the count so the pads see no
    // combinational encode glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            code_reg  <= '0;
        end else begin
            count_reg <= count_next;
            code_reg  <= code_next;
        end
    end

    assign tc   = (count_reg == CNT_LAST);
    assign data = run ? code_reg : 'z;

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer for a 4-pixel array on a shared tri-state DATA bus:
// ERASE -> EXPOSE -> CONVERT (ramp count on DATA) -> TURN -> per pixel
// RD_SETTLE/RD_OUT -> DONE. Pixel codes are streamed out over valid/ready.
// Optional build macro: DATA_GRAY_EN (Gray ramp on DATA, sampled codes decoded to binary).
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   start             frame request, honoured only in IDLE
//   ERASE, EXPOSE     pixel strobes
//   CONVERT           ramp enable; DATA carries the count while high
//   READ[3:0]         one-hot pixel read select
//   DATA              shared pixel bus (inout)
//   pix_data/pix_idx  sampled code and its pixel index, qualified by pix_valid
//   pix_ready         downstream accept
//   busy              any state other than IDLE
//   frame_done        one-cycle pulse after pixel 3 is accepted
module pixel_readout_ctrl
    import pixel_readout_pkg::*;
#(
    parameter int C_ERASE  = 5,
    parameter int C_EXPOSE = 255,
    parameter int C_SETTLE = 2,
    parameter int DW       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ERASE,
    output logic             EXPOSE,
    output logic             CONVERT,
    output logic [NPIX-1:0]  READ,
    inout  wire  [DW-1:0]    DATA,
    output logic [DW-1:0]    pix_data,
    output logic [IDX_W-1:0] pix_idx,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [15:0]      ERASE_LAST  = 16'(C_ERASE - 1);
    localparam logic [15:0]      EXPOSE_LAST = 16'(C_EXPOSE - 1);
    localparam logic [15:0]      SETTLE_LAST = 16'(C_SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NPIX - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [15:0]      timer_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [DW-1:0]    sample_reg;
    logic [DW-1:0]    sample_code;
    logic             conv_tc;

    pixel_conv_counter #(
        .DW (DW)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .run   (CONVERT),
        .data  (DATA),
        .tc    (conv_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (start) state_next = ST_ERASE;
            ST_ERASE:     if (timer_reg == ERASE_LAST) state_next = ST_EXPOSE;
            ST_EXPOSE:    if (timer_reg == EXPOSE_LAST) state_next = ST_CONVERT;
            ST_CONVERT:   if (conv_tc) state_next = ST_TURN;
            ST_TURN:      state_next = ST_RD_SETTLE;
            ST_RD_SETTLE: if (timer_reg == SETTLE_LAST) state_next = ST_RD_OUT;
            ST_RD_OUT:    if (pix_ready) state_next = (idx_reg == IDX_LAST) ? ST_DONE : ST_RD_SETTLE;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ERASE      = 1'b0;
        EXPOSE     = 1'b0;
        CONVERT    = 1'b0;
        READ       = '0;
        pix_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = (state_reg != ST_IDLE);
        case (state_reg)
            ST_ERASE:     ERASE = 1'b1;
            ST_EXPOSE:    EXPOSE = 1'b1;
            ST_CONVERT:   CONVERT = 1'b1;
            ST_RD_SETTLE: READ[idx_reg] = 1'b1;
            ST_RD_OUT:    pix_valid = 1'b1;
            ST_DONE:      frame_done = 1'b1;
            default:      ;
        endcase
    end

`ifdef DATA_GRAY_EN
    assign sample_code = DW'(gray2bin(CODE_MAX_W'(DATA), DW));
`else
    assign sample_code = DATA;
`endif

    // The timer restarts on every state change; timed states always leave
    // before it can wrap. Unknown bus bits flow straight into pix_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_reg  <= '0;
            idx_reg    <= '0;
            sample_reg <= '0;
        end else begin
            timer_reg <= (state_next != state_reg) ? 16'd0 : timer_reg + 16'd1;
            if (state_reg == ST_TURN || state_reg == ST_DONE) begin
                idx_reg <= '0;
            end else if (state_reg == ST_RD_OUT && pix_ready && idx_reg != IDX_LAST) begin
                idx_reg <= idx_reg + 1'b1;
            end
            if (state_reg == ST_RD_SETTLE && timer_reg == SETTLE_LAST) begin
                sample_reg <= sample_code;
            end
        end
    end

    assign pix_data = sample_reg;
    assign pix_idx  = idx_reg;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl (C_ERASE=2, C_EXPOSE=3, C_SETTLE=2, DW=4).
// Pixel models latch codes 3,7,11,15 (Gray-encoded on the bus when DATA_GRAY_EN is defined).
module tb_pixel_readout_ctrl;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          pix_ready = 1'b1;
    logic          ERASE, EXPOSE, CONVERT;
    logic [3:0]    READ;
    wire  [DW-1:0] DATA;
    logic [DW-1:0] pix_data;
    logic [1:0]    pix_idx;
    logic          pix_valid, busy, frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixel_readout_ctrl #(
        .C_ERASE  (2),
        .C_EXPOSE (3),
        .C_SETTLE (2),
        .DW       (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ERASE      (ERASE),
        .EXPOSE     (EXPOSE),
        .CONVERT    (CONVERT),
        .READ       (READ),
        .DATA       (DATA),
        .pix_data   (pix_data),
        .pix_idx    (pix_idx),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    function automatic logic [DW-1:0] enc(input int v);
        logic [DW-1:0] b;
        b = DW'(v);
`ifdef DATA_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // Pixel array model: the selected pixel drives its latched ramp code.
    logic [DW-1:0] pix_drive;
    logic          pix_drive_en;
    always_comb begin
        pix_drive    = '0;
        pix_drive_en = |READ;
        for (int n = 0; n < 4; n++) begin
            if (READ[n]) pix_drive = enc(4 * n + 3);
        end
    end
    assign DATA = pix_drive_en ? pix_drive : 'z;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Per-run observations
    int            n_erase, n_expose, n_conv, conv_bad, overlap, contend, multi, turn_bad;
    int            n_out, n_done, starts, stalled, stall_bad;
    int            done_cyc[2];
    int            start_cyc[2];
    logic [DW-1:0] got_data[8];
    logic [1:0]    got_idx[8];
    logic          last_busy;

    task automatic run(input int cycles, input int stall, input bit hold);
        logic prev_erase, prev_conv, turn_seen, ready_now;
        int   conv_idx;
        n_erase = 0; n_expose = 0; n_conv = 0; conv_bad = 0; overlap = 0; contend = 0;
        multi = 0; turn_bad = 0; n_out = 0; n_done = 0; starts = 0; stalled = 0; stall_bad = 0;
        done_cyc[0] = -1; done_cyc[1] = -1; start_cyc[0] = -1; start_cyc[1] = -1;
        prev_erase = 1'b0; prev_conv = 1'b0; turn_seen = 1'b0; conv_idx = 0; last_busy = 1'b1;
        for (int cyc = 1; cyc <= cycles; cyc++) begin
            @(posedge clk);
            #1;
            if (!hold) start = 1'b0;
            if (ERASE && !prev_erase) begin
                if (starts < 2) start_cyc[starts] = cyc;
                starts++;
                conv_idx = 0;
                if (hold && starts == 2) start = 1'b0;
            end
            if (ERASE) n_erase++;
            if (EXPOSE) n_expose++;
            if (ERASE && EXPOSE) overlap++;
            if (CONVERT) begin
                n_conv++;
                if (DATA !== enc(conv_idx)) conv_bad++;
                conv_idx++;
            end
            if (READ != 4'b0000 && CONVERT) contend++;
            if (!$onehot0(READ)) multi++;
            if (prev_conv && !CONVERT) begin
                if (READ != 4'b0000 || !busy) turn_bad++;
                turn_seen = 1'b1;
            end else if (turn_seen) begin
                if (READ !== 4'b0001) turn_bad++;
                turn_seen = 1'b0;
            end
            ready_now = 1'b1;
            if (pix_valid && pix_idx == 2'd1 && stalled < stall) begin
                ready_now = 1'b0;
                stalled++;
                if (pix_data !== 4'd7 || READ != 4'b0000) stall_bad++;
            end
            pix_ready = ready_now;
            if (pix_valid && ready_now) begin
                if (n_out < 8) begin
                    got_idx[n_out]  = pix_idx;
                    got_data[n_out] = pix_data;
                end
                n_out++;
            end
            if (frame_done) begin
                if (n_done < 2) done_cyc[n_done] = cyc;
                n_done++;
            end
            prev_erase = ERASE;
            prev_conv  = CONVERT;
            last_busy  = busy;
        end
        pix_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int stall, input int frames);
        check({tag, ".erase_cycles"}, n_erase, 2 * frames);
        check({tag, ".expose_cycles"}, n_expose, 3 * frames);
        check({tag, ".convert_cycles"}, n_conv, 16 * frames);
        check({tag, ".convert_data_bad"}, conv_bad, 0);
        check({tag, ".erase_expose_overlap"}, overlap, 0);
        check({tag, ".bus_contention"}, contend, 0);
        check({tag, ".read_not_onehot"}, multi, 0);
        check({tag, ".turn_bad"}, turn_bad, 0);
        check({tag, ".frame_starts"}, starts, frames);
        check({tag, ".outputs"}, n_out, 4 * frames);
        check({tag, ".frame_done_pulses"}, n_done, frames);
        check({tag, ".start_cycle"}, start_cyc[0], 1);
        check({tag, ".done_cycle"}, done_cyc[0], 35 + stall);
        check({tag, ".stall_cycles"}, stalled, stall);
        check({tag, ".stall_bad"}, stall_bad, 0);
        check({tag, ".busy_after"}, 32'(last_busy), 0);
        for (int k = 0; k < 4 * frames; k++) begin
            check($sformatf("%s.idx%0d", tag, k), 32'(got_idx[k]), k % 4);
            check($sformatf("%s.data%0d", tag, k), 32'(got_data[k]), 4 * (k % 4) + 3);
        end
    endtask

    initial begin
        bit found;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.erase", 32'(ERASE), 0);
        check("rst.expose", 32'(EXPOSE), 0);
        check("rst.convert", 32'(CONVERT), 0);
        check("rst.read", 32'(READ), 0);
        check("rst.pix_valid", 32'(pix_valid), 0);
        check("rst.pix_data", 32'(pix_data), 0);
        check("rst.pix_idx", 32'(pix_idx), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.frame_done", 32'(frame_done), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle.busy", 32'(busy), 0);

        // Single frame, pix_ready held high
        start = 1'b1;
        run(45, 0, 1'b0);
        check_frame("f1", 0, 1);

        // Downstream stall of 5 cycles on pixel 1
        start = 1'b1;
        run(50, 5, 1'b0);
        check_frame("stall", 5, 1);

        // Asynchronous reset in the middle of CONVERT at count 9
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (CONVERT && DATA === enc(9)) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("arst.reached_count9", 32'(found), 1);
        #2 reset = 1'b0;
        #1;
        check("arst.convert", 32'(CONVERT), 0);
        check("arst.read", 32'(READ), 0);
        check("arst.pix_valid", 32'(pix_valid), 0);
        check("arst.busy", 32'(busy), 0);
        check("arst.frame_done", 32'(frame_done), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        run(45, 0, 1'b0);
        check_frame("post_rst", 0, 1);

        // start held high: two back-to-back frames, second starts after the IDLE cycle
        start = 1'b1;
        run(100, 0, 1'b1);
        check_frame("held", 0, 2);
        check("held.second_start", start_cyc[1], done_cyc[0] + 2);
        check("held.second_done", done_cyc[1], 71);
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
